wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline writeback (WR/WD from the
//  writeback stage) and a long-latency auxiliary source (late load returns / multicycle unit results).
//  Queues auxiliary writes, arbitrates per cycle, squashes stale queued writes (WAW) and drives a
//  registered write to the register file. Sits between the writeback stage and the register file.
// PARAMETERS
//  AUX_DEPTH   2   auxiliary queue entries (power of two, >=2)
//  STARVE_MAX  4   consecutive pipe grants while aux queue non-empty before aux is forced
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  pipe_valid     in   1   pipeline writeback request
//  pipe_wr        in   3   pipeline destination register
//  pipe_wd        in   16  pipeline write data
//  pipe_ready     out  1   pipe request accepted this cycle; low = pipeline must stall
//  aux_valid      in   1   auxiliary write request
//  aux_wr         in   3   auxiliary destination register
//  aux_wd         in   16  auxiliary write data
//  aux_ready      out  1   aux queue not full (combinational from queue count only)
//  rf_we          out  1   register-file write enable (registered)
//  rf_wr          out  3   register-file write register (registered)
//  rf_wd          out  16  register-file write data (registered)
//  aux_pending    out  1   queue holds >=1 live (unkilled) entry
//  err            out  1   constant 0; reserved
// BEHAVIOUR
//  - Reset (async, rst=1): queue empty, all kill bits 0, starve counter 0, rf_we=0, rf_wr=0, rf_wd=0.
//  - aux push: aux_valid && aux_ready -> append {wr,wd,kill=0} at tail; aux data valid same cycle.
//  - Grant (per cycle, combinational): force_aux = live head && starve==STARVE_MAX.
//    PIPE if pipe_valid && !force_aux; else AUX if queue non-empty; else NONE.
//    pipe_ready = !force_aux (high even when pipe_valid low).
//  - Starve counter: +1 on PIPE grant while live head exists; cleared on AUX pop or queue empty; saturates.
//  - Killed head: popped without write and without consuming the port (PIPE may still win that cycle);
//    does not touch the starve counter; at most one pop per cycle.
//  - WAW squash: on PIPE grant, every queued entry with wr==pipe_wr sets kill=1 (pipe write is younger).
//    Entry pushed in the same cycle with same wr is NOT killed (it is younger than the pipe write).
//  - Output register: next cycle rf_we=1 with granted wr/wd; rf_we=0 on NONE or killed-head pop. Latency 1.
//  - Simultaneous push and pop when full: aux_ready is low, no push; pop proceeds.
//  - Pointer wrap: head/tail modulo AUX_DEPTH; count 0..AUX_DEPTH distinguishes full/empty.
//  - rst mid-operation: queued entries discarded, in-flight rf write dropped (rf_we=0 immediately).
// CONFIGURATION
//  WB_ARB_PERF_EN defined: adds out 16-bit stall_cnt (cycles pipe_valid && !pipe_ready) and 16-bit
//  squash_cnt (entries killed); both saturate at 16'hFFFF, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared include wb_arb_defs.vh: grant encodings (GNT_NONE=2'b00, GNT_PIPE=2'b01, GNT_AUX=2'b10),
//  REG_W=3, DATA_W=16.
//  Sub-module wb_aux_fifo: storage, head/tail/count, per-entry kill bits with parallel tag compare;
//  arbitration, starve counter and output register stay in top.
// TESTING
//  1 Reset: rst pulsed mid-stream with 2 queued entries -> rf_we=0 same cycle, aux_pending=0, aux_ready=1.
//  2 Pipe only: pipe wr=3 wd=16'h1234 -> next cycle rf_we=1, rf_wr=3, rf_wd=16'h1234; pipe_ready=1.
//  3 Idle aux: aux wr=5 wd=16'hBEEF, pipe_valid=0 -> write appears 2 cycles after push (queue+reg).
//  4 Starvation: aux queued, pipe_valid held -> 4 pipe writes, then pipe_ready=0 one cycle, aux written.
//  5 WAW: queue aux wr=2 wd=16'hAAAA, then pipe wr=2 wd=16'h5555 -> only 16'h5555 written to r2;
//    killed pop writes nothing; squash_cnt=1 when WB_ARB_PERF_EN.
//  6 Full: push AUX_DEPTH entries with pipe saturating -> aux_ready=0; pop and push same cycle keep order.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: field widths, grant
// encodings and a saturating add helper used by the optional perf counters.
package wb_port_arbiter_pkg;

    localparam int REG_W  = 3;
    localparam int DATA_W = 16;

    // Per-cycle grant encodings for the register-file write port.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_PIPE = 2'b01;
    localparam logic [1:0] GNT_AUX  = 2'b10;

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/wb_aux_fifo.sv
// Auxiliary write queue: circular storage with head/tail/count and a kill
// bit per entry. A squash request compares its register tag against every
// live entry in parallel and marks matches as killed.
module wb_aux_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [REG_W-1:0]             push_wr_i,
    input  logic [DATA_W-1:0]            push_wd_i,
    input  logic                         pop_i,
    input  logic                         squash_i,
    input  logic [REG_W-1:0]             squash_wr_i,
    output logic [REG_W-1:0]             head_wr_o,
    output logic [DATA_W-1:0]            head_wd_o,
    output logic                         head_kill_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         live_any_o,
    output logic [$clog2(DEPTH+1)-1:0]   squash_num_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [REG_W-1:0]  wr_q [DEPTH];
    logic [DATA_W-1:0] wd_q [DEPTH];
    logic [DEPTH-1:0]  kill_q, kill_d, valid_v, kill_set;
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;

    // Occupancy mask from head/count, and the parallel tag compare for squash.
    // The slot being pushed this cycle is not yet valid, so it is never killed.
    always_comb begin
        valid_v      = '0;
        kill_set     = '0;
        squash_num_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_v[i]   = CW'(PW'(i) - head_q) < count_q;
            kill_set[i]  = squash_i && valid_v[i] && !kill_q[i] && (wr_q[i] == squash_wr_i);
            squash_num_o = squash_num_o + CW'(kill_set[i]);
        end
    end

    // Next kill bits: new squashes accumulate; a freshly pushed slot starts live.
    always_comb begin
        kill_d = kill_q | kill_set;
        if (push_i) kill_d[tail_q] = 1'b0;
    end

    // Pointer, count and kill-bit state; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            kill_q  <= '0;
        end else begin
            if (pop_i)  head_q <= head_q + 1'b1;
            if (push_i) tail_q <= tail_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
            kill_q  <= kill_d;
        end
    end

    // Entry payload storage; occupancy is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            wr_q[tail_q] <= push_wr_i;
            wd_q[tail_q] <= push_wd_i;
        end
    end

    assign head_wr_o   = wr_q[head_q];
    assign head_wd_o   = wd_q[head_q];
    assign head_kill_o = kill_q[head_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign live_any_o  = |(valid_v & ~kill_q);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between pipeline writeback and a queued
// auxiliary source, with starvation forcing and WAW squash of stale entries.
// Optional feature macro: WB_ARB_PERF_EN adds stall_cnt / squash_cnt outputs.
// Handshake: pipe_ready high = pipe request (if valid) is taken this cycle;
// aux_ready high = queue has room, aux request is pushed when aux_valid is high.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int AUX_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [REG_W-1:0]  pipe_wr,
    input  logic [DATA_W-1:0] pipe_wd,
    output logic              pipe_ready,
    input  logic              aux_valid,
    input  logic [REG_W-1:0]  aux_wr,
    input  logic [DATA_W-1:0] aux_wd,
    output logic              aux_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wr,
    output logic [DATA_W-1:0] rf_wd,
    output logic              aux_pending,
    output logic              err
`ifdef WB_ARB_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       squash_cnt
`endif
);

    localparam int SW = $clog2(STARVE_MAX+1);
    localparam int CW = $clog2(AUX_DEPTH+1);

    logic              q_empty, q_full, q_head_kill, q_live_any;
    logic [REG_W-1:0]  q_head_wr;
    logic [DATA_W-1:0] q_head_wd;
    logic [CW-1:0]     q_squash_num;
    logic              head_live, force_aux, push, pop;
    logic [1:0]        grant;
    logic [SW-1:0]     starve_q, starve_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_wr_q, rf_wr_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

    wb_aux_fifo #(.DEPTH(AUX_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_wr_i    (aux_wr),
        .push_wd_i    (aux_wd),
        .pop_i        (pop),
        .squash_i     (grant == GNT_PIPE),
        .squash_wr_i  (pipe_wr),
        .head_wr_o    (q_head_wr),
        .head_wd_o    (q_head_wd),
        .head_kill_o  (q_head_kill),
        .empty_o      (q_empty),
        .full_o       (q_full),
        .live_any_o   (q_live_any),
        .squash_num_o (q_squash_num)
    );

    assign head_live = !q_empty && !q_head_kill;
    assign force_aux = head_live && (starve_q == SW'(STARVE_MAX));

    // Per-cycle grant: pipe wins unless the aux head has waited too long.
    always_comb begin
        grant = GNT_NONE;
        if (pipe_valid && !force_aux) grant = GNT_PIPE;
        else if (head_live)           grant = GNT_AUX;
    end

    // A killed head drains for free alongside whatever wins the port.
    assign pop         = !q_empty && (q_head_kill || grant == GNT_AUX);
    assign push        = aux_valid && !q_full;
    assign pipe_ready  = !force_aux;
    assign aux_ready   = !q_full;
    assign aux_pending = q_live_any;
    assign err         = 1'b0;

    // Next-state for the write register and the starvation counter.
    always_comb begin
        rf_we_d  = 1'b0;
        rf_wr_d  = rf_wr_q;
        rf_wd_d  = rf_wd_q;
        starve_d = starve_q;
        case (grant)
            GNT_PIPE: begin rf_we_d = 1'b1; rf_wr_d = pipe_wr;   rf_wd_d = pipe_wd;   end
            GNT_AUX:  begin rf_we_d = 1'b1; rf_wr_d = q_head_wr; rf_wd_d = q_head_wd; end
            default:  ;
        endcase
        if (grant == GNT_AUX || q_empty)
            starve_d = '0;
        else if (grant == GNT_PIPE && head_live && starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    // Registered write port and starvation state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q  <= 1'b0;
            rf_wr_q  <= '0;
            rf_wd_q  <= '0;
            starve_q <= '0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_wr_q  <= rf_wr_d;
            rf_wd_q  <= rf_wd_d;
            starve_q <= starve_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wr = rf_wr_q;
    assign rf_wd = rf_wd_q;

`ifdef WB_ARB_PERF_EN
    logic [15:0] stall_cnt_q, squash_cnt_q;

    // Saturating counts of pipeline stall cycles and squashed aux entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= sat_add16(stall_cnt_q, 16'(pipe_valid && !pipe_ready));
            squash_cnt_q <= sat_add16(squash_cnt_q, 16'(q_squash_num));
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign squash_cnt = squash_cnt_q;
`else
    logic squash_num_unused;
    assign squash_num_unused = ^q_squash_num;
`endif

endmodule
